// File: rtl/run_stats_pkg.sv
// run_stats_pkg: state encoding and default widths shared by the run statistics monitor.
package run_stats_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LONG = 2'd2
  } state_e;
  localparam int CNT_W_DEF = 8;
  localparam int RUN_W_DEF = 4;
endpackage

// File: rtl/run_stats_monitor_sat_counter.sv
// sat_counter: saturating up-counter with synchronous reset and clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q;
  always_ff @(posedge clk)
    q_q <= (rst || clr) ? '0 : (inc && !(&q_q)) ? q_q + 1'b1 : q_q;
  assign q = q_q;
endmodule

// File: rtl/run_stats_monitor.sv
// run_stats_monitor: measures runs of consecutive match strobes, keeps last/longest run,
// run and long-run counts, and a sticky alarm when a run reaches ALARM_RUN.
module run_stats_monitor
  import run_stats_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int RUN_W     = RUN_W_DEF,
  parameter int ALARM_RUN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             match_in,
  input  logic             clr,
  input  logic             alarm_ack,
  output logic [RUN_W-1:0] run_len,
  output logic [RUN_W-1:0] last_run,
  output logic [RUN_W-1:0] max_run,
  output logic [CNT_W-1:0] run_count,
  output logic [CNT_W-1:0] long_count,
  output logic             run_done,
  output logic             alarm
);
  localparam logic [RUN_W-1:0] LEN_MAX = '1;
  localparam logic [RUN_W-1:0] ALARM   = RUN_W'(ALARM_RUN);
  state_e state_q, state_d;
  logic [RUN_W-1:0] run_len_q, run_len_d, last_q, last_d, max_q, max_d;
  logic done_q, alarm_q, alarm_d, start, hit, run_end, long_end;
  always_comb begin
    state_d   = state_q;
    run_len_d = run_len_q;
    start     = 1'b0;
    hit       = 1'b0;
    run_end   = 1'b0;
    case (state_q)
      ST_IDLE: if (match_in) begin
        state_d   = ST_RUN;
        run_len_d = RUN_W'(1);
        start     = 1'b1;
      end
      ST_RUN: if (match_in) begin
        run_len_d = run_len_q + 1'b1;
        hit       = run_len_d == ALARM;
        state_d   = hit ? ST_LONG : ST_RUN;
      end else run_end = 1'b1;
      ST_LONG: if (match_in) run_len_d = run_len_q + RUN_W'(run_len_q != LEN_MAX);
               else run_end = 1'b1;
      default: state_d = ST_IDLE;
    endcase
    if (run_end) begin
      state_d   = ST_IDLE;
      run_len_d = '0;
    end
  end
  assign long_end = run_end && state_q == ST_LONG;
  // clr wins over every statistic update but leaves the live run alone
  assign last_d  = clr ? '0 : run_end ? run_len_q : last_q;
  assign max_d   = clr ? '0 : (run_end && run_len_q > max_q) ? run_len_q : max_q;
  assign alarm_d = clr ? 1'b0 : hit ? 1'b1 : alarm_ack ? 1'b0 : alarm_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      run_len_q <= '0;
      last_q    <= '0;
      max_q     <= '0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_len_q <= run_len_d;
      last_q    <= last_d;
      max_q     <= max_d;
      done_q    <= run_end;
      alarm_q   <= alarm_d;
    end
  end
  sat_counter #(.W(CNT_W)) u_runs (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (start),
    .q   (run_count)
  );
  sat_counter #(.W(CNT_W)) u_longs (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (long_end),
    .q   (long_count)
  );
  assign run_len  = run_len_q;
  assign last_run = last_q;
  assign max_run  = max_q;
  assign run_done = done_q;
  assign alarm    = alarm_q;
endmodule

// File: tb/tb_run_stats_monitor.sv
// tb_run_stats_monitor: scoreboard bench driving directed and random match patterns.
module tb_run_stats_monitor;
  logic clk = 1'b0, rst, match_in, clr, alarm_ack;
  logic [3:0] run_len, last_run, max_run;
  logic [7:0] run_count, long_count;
  logic run_done, alarm;
  int n_chk = 0, n_err = 0;

  typedef struct {
    int len, last, mx, cnt, lng, done, alm;
  } exp_t;
  exp_t sb[$];

  int m_len = 0, m_last = 0, m_max = 0, m_cnt = 0, m_lng = 0, m_done = 0, m_alm = 0;

  always #5 clk = ~clk;

  run_stats_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .match_in   (match_in),
    .clr        (clr),
    .alarm_ack  (alarm_ack),
    .run_len    (run_len),
    .last_run   (last_run),
    .max_run    (max_run),
    .run_count  (run_count),
    .long_count (long_count),
    .run_done   (run_done),
    .alarm      (alarm)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // reference model: a run is "active" whenever the model length is nonzero
  task automatic model(input bit r, input bit m, input bit c, input bit a);
    bit ending, hit;
    exp_t e;
    if (r) begin
      m_len = 0; m_last = 0; m_max = 0; m_cnt = 0; m_lng = 0; m_done = 0; m_alm = 0;
    end else begin
      ending = m_len > 0 && !m;
      hit    = m_len > 0 && m && m_len + 1 == 4;
      m_done = ending;
      if (ending) begin
        m_last = m_len;
        if (m_len > m_max) m_max = m_len;
        if (m_len >= 4 && m_lng < 255) m_lng++;
        m_len = 0;
      end
      if (m) begin
        if (m_len == 0 && m_cnt < 255) m_cnt++;
        if (m_len < 15) m_len++;
      end
      if (c) begin
        m_cnt = 0; m_lng = 0; m_last = 0; m_max = 0;
      end
      m_alm = c ? 0 : hit ? 1 : a ? 0 : m_alm;
    end
    e = '{m_len, m_last, m_max, m_cnt, m_lng, m_done, m_alm};
    sb.push_back(e);
  endtask

  task automatic step(input bit r, input bit m, input bit c = 0, input bit a = 0);
    exp_t e;
    rst = r; match_in = m; clr = c; alarm_ack = a;
    model(r, m, c, a);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("run_len",    int'(run_len),    e.len);
    chk("last_run",   int'(last_run),   e.last);
    chk("max_run",    int'(max_run),    e.mx);
    chk("run_count",  int'(run_count),  e.cnt);
    chk("long_count", int'(long_count), e.lng);
    chk("run_done",   int'(run_done),   e.done);
    chk("alarm",      int'(alarm),      e.alm);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 1);
    step(0, 0);
  endtask

  initial begin
    step(1, 1); step(1, 1);
    chk("rst_len", int'(run_len), 0);
    chk("rst_cnt", int'(run_count), 0);
    step(0, 1);
    chk("first_len", int'(run_len), 1);
    chk("first_cnt", int'(run_count), 1);
    step(0, 0);
    step(0, 0, 1);
    run(3);
    chk("short_last", int'(last_run), 3);
    chk("short_max", int'(max_run), 3);
    chk("short_done", int'(run_done), 1);
    chk("short_alarm", int'(alarm), 0);
    step(0, 0);
    chk("done_pulse", int'(run_done), 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1);
      if (i == 3) chk("alarm_at4", int'(alarm), 1);
    end
    step(0, 0);
    chk("long_last", int'(last_run), 6);
    chk("long_cnt", int'(long_count), 1);
    chk("alarm_sticky", int'(alarm), 1);
    step(0, 0, 0, 1);
    chk("alarm_ack", int'(alarm), 0);
    step(0, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 1);
    chk("len_sat", int'(run_len), 15);
    step(0, 0);
    for (int i = 0; i < 300; i++) run(1);
    chk("cnt_sat", int'(run_count), 255);
    step(0, 0, 1);
    run(5); run(2); run(7); run(3);
    chk("mx_last", int'(last_run), 3);
    chk("mx_max", int'(max_run), 7);
    chk("mx_long", int'(long_count), 2);
    chk("mx_cnt", int'(run_count), 4);
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 1);
    step(0, 0, 1);
    chk("clr_end_last", int'(last_run), 0);
    chk("clr_end_max", int'(max_run), 0);
    chk("clr_end_long", int'(long_count), 0);
    chk("clr_end_done", int'(run_done), 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1);
    step(0, 1, 0, 1);
    chk("set_beats_ack", int'(alarm), 1);
    step(0, 0);
    for (int i = 0; i < 3; i++) step(0, 1);
    step(1, 0);
    chk("rst_mid_len", int'(run_len), 0);
    chk("rst_mid_done", int'(run_done), 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/run_stats_monitor.md
Name: run_stats_monitor

Overview:
- Downstream consumer of the consecutive-ones detector's strobe output (z = w AND previous w).
- Tracks runs of consecutive asserted match cycles: counts runs, measures run length, keeps last and longest run, raises a sticky alarm when a run reaches a threshold.
- Statistics are cleared by software without disturbing the run currently being measured.

Parameters:
CNT_W, 8, width of run and long-run counters (saturating)
RUN_W, 4, width of run-length registers (saturating at 2^RUN_W-1)
ALARM_RUN, 4, run length that declares a long run; legal range 2..2^RUN_W-1

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
match_in  in  1  detector strobe (z), sampled every cycle
clr  in  1  synchronous statistics clear, active-high
alarm_ack  in  1  clears sticky alarm
run_len  out  RUN_W  length of run in progress, 0 when idle
last_run  out  RUN_W  length of most recently completed run
max_run  out  RUN_W  longest completed run since rst/clr
run_count  out  CNT_W  number of runs started
long_count  out  CNT_W  number of completed runs that reached ALARM_RUN
run_done  out  1  one-cycle pulse, cycle after a run ends
alarm  out  1  sticky, set on reaching ALARM_RUN

Behaviour:
- Reset: rst=1 at a clock edge puts all outputs to 0 and state to IDLE; rst has priority over everything, including mid-run.
- All outputs are registered; no combinational path from any input to any output.
- States:
  - IDLE, no run.
  - RUN, run in progress below threshold.
  - LONG, run in progress at or above threshold.
- IDLE:
  - match_in=1 -> RUN, run_len<=1, run_count+1.
  - match_in=0 -> stay.
- RUN, match_in=1:
  - run_len+1.
  - If the new value equals ALARM_RUN -> LONG and alarm<=1 in the same edge.
- RUN, match_in=0 -> IDLE:
  - last_run<=run_len.
  - max_run<=max(max_run, run_len).
  - run_len<=0.
  - run_done<=1 for exactly one cycle.
- LONG:
  - match_in=1 -> run_len+1, saturating at 2^RUN_W-1 and holding there.
  - match_in=0 -> same end-of-run actions as RUN, plus long_count+1.
- Back-to-back runs are impossible (a run ends only on match_in=0). The earliest next run starts the cycle after run_done rises.
- Counters run_count and long_count saturate at 2^CNT_W-1; no wrap.
- alarm:
  - Set on entry to LONG.
  - Cleared on alarm_ack=1.
  - Set and ack in the same cycle -> set wins (alarm=1).
  - Not cleared by the run ending.
- clr:
  - Zeroes run_count, long_count, last_run, max_run and alarm.
  - Does not touch state or run_len; the run in progress continues.
  - clr has priority over statistic updates in the same cycle.
  - clr at run start: run_count=0, not 1.
  - clr at run end: last_run, max_run and long_count stay 0, but run_done still pulses and run_len still goes to 0.
  - clr with alarm set in the same cycle: alarm=0.
- Latency: match_in at edge N is reflected in run_len/state at edge N; a run ending at edge N gives run_done high from N until N+1.

Decomposition:
- Shared package run_stats_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_LONG=2'd2.
  - default widths CNT_W_DEF=8, RUN_W_DEF=4.
- One natural sub-module, sat_counter: parameter W; inputs clk, rst, clr, inc; output q; saturating at all-ones. Instantiated for run_count and long_count.
- The FSM, run_len, max/last logic and alarm live in the top module.

Test Plan:
- Reset: drive rst=1 for 2 cycles with match_in=1 -> all outputs 0, state IDLE; release rst, match_in=1 next edge -> run_len=1, run_count=1.
- Short run: match_in high 3 cycles then low -> run_len 1,2,3 then 0; last_run=3, max_run=3, run_done pulses 1 cycle, alarm=0, long_count=0.
- Long run: match_in high 6 cycles -> alarm rises on the edge where run_len=4, run_len=6; after low: last_run=6, long_count=1, alarm stays 1; alarm_ack=1 -> alarm=0.
- Saturation: match_in high 20 cycles -> run_len holds 15; then 300 separate 1-cycle runs -> run_count holds 255.
- Max tracking: runs of 5, 2, 7, 3 -> last_run=3, max_run=7, long_count=2, run_count=4.
- Collisions:
  - clr on the run-ending edge of a 5-run -> last_run=0, max_run=0, long_count=0, run_done=1.
  - alarm_ack on the edge run_len reaches 4 -> alarm=1.
  - rst mid-run at run_len=3 -> run_len=0, no run_done.
